// File: rtl/pulse_pkg.sv
// Shared types and helpers for the pulse-family blocks.
// Holds the FSM state type, default width and config sanitisation.
package pulse_pkg;

  localparam int CNT_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    HIGH,
    LOW
  } pulse_gen_state_t;

  // Clamp a pulse width to [1, 2^cw-2] so width+1 still fits in cw bits.
  function automatic logic [63:0] san_width(
    input logic [63:0] w,
    input int          cw
  );
    logic [63:0] hi;
    hi = ({64{1'b1}} >> (64 - cw)) - 64'd1;
    if (w == 64'd0) return 64'd1;
    if (w > hi) return hi;
    return w;
  endfunction

  // Guarantee at least one low cycle between pulses.
  function automatic logic [63:0] san_period(
    input logic [63:0] p,
    input logic [63:0] w
  );
    if (p > w) return p;
    return w + 64'd1;
  endfunction

endpackage

// File: rtl/pulse_train_gen.sv
// Delayed, bounded or free-running fixed-width pulse train generator.
// Define PULSE_TRAIN_GEN_IDX_OUT_EN to expose the pulse_idx port.
module pulse_train_gen
  import pulse_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic [CNT_W-1:0] delay_num,
  input  logic [CNT_W-1:0] width_num,
  input  logic [CNT_W-1:0] period_num,
  input  logic [CNT_W-1:0] pulse_cnt,
  output logic             pulse_out,
  output logic             busy,
  output logic             done
`ifdef PULSE_TRAIN_GEN_IDX_OUT_EN
  ,
  output logic [CNT_W-1:0] pulse_idx
`endif
);

  pulse_gen_state_t state;

  logic [CNT_W-1:0] ph;
  logic [CNT_W-1:0] emitted;
  logic [CNT_W-1:0] width_q;
  logic [CNT_W-1:0] low_q;
  logic [CNT_W-1:0] cnt_q;

  logic [CNT_W-1:0] w_san;
  logic [CNT_W-1:0] p_san;
  logic             last;

  // Sanitised config, only consumed at start acceptance.
  always_comb begin
    w_san = CNT_W'(san_width(64'(width_num), CNT_W));
    p_san = CNT_W'(san_period(64'(period_num), 64'(w_san)));
  end

  // The pulse just finishing is the final one of a bounded train.
  always_comb begin
    last = (cnt_q != '0) && (emitted == cnt_q);
  end

  // Main FSM; phase counter counts down the current DELAY/HIGH/LOW span.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ph        <= '0;
      emitted   <= '0;
      width_q   <= '0;
      low_q     <= '0;
      cnt_q     <= '0;
      pulse_out <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef PULSE_TRAIN_GEN_IDX_OUT_EN
      pulse_idx <= '0;
`endif
    end else begin
      done <= 1'b0;
      if (state != IDLE && stop) begin
        state     <= IDLE;
        pulse_out <= 1'b0;
        busy      <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (start) begin
              width_q <= w_san;
              low_q   <= p_san - w_san - 1'b1;
              cnt_q   <= pulse_cnt;
              busy    <= 1'b1;
`ifdef PULSE_TRAIN_GEN_IDX_OUT_EN
              pulse_idx <= '0;
`endif
              if (delay_num == '0) begin
                state     <= HIGH;
                ph        <= w_san - 1'b1;
                pulse_out <= 1'b1;
                emitted   <= CNT_W'(1);
              end else begin
                state   <= DELAY;
                ph      <= delay_num - 1'b1;
                emitted <= '0;
              end
            end
          end
          DELAY, LOW: begin
            if (ph == '0) begin
              state     <= HIGH;
              ph        <= width_q - 1'b1;
              pulse_out <= 1'b1;
              emitted   <= emitted + 1'b1;
`ifdef PULSE_TRAIN_GEN_IDX_OUT_EN
              pulse_idx <= emitted;
`endif
            end else begin
              ph <= ph - 1'b1;
            end
          end
          HIGH: begin
            if (ph == '0) begin
              pulse_out <= 1'b0;
              if (last) begin
                state <= IDLE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end else begin
                state <= LOW;
                ph    <= low_q;
              end
            end else begin
              ph <= ph - 1'b1;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pulse_train_gen.sv
// Scoreboard bench for pulse_train_gen against an arithmetic train model.
// Expected outputs are queued per cycle and checked by a monitor.
module tb_pulse_train_gen;

  localparam int W = 32;
  localparam longint MAXW = (64'd1 << W) - 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         stop = 1'b0;
  logic [W-1:0] delay_num = '0;
  logic [W-1:0] width_num = '0;
  logic [W-1:0] period_num = '0;
  logic [W-1:0] pulse_cnt = '0;
  logic         pulse_out;
  logic         busy;
  logic         done;
  logic [W-1:0] pulse_idx;

  pulse_train_gen #(.CNT_W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stop      (stop),
    .delay_num (delay_num),
    .width_num (width_num),
    .period_num(period_num),
    .pulse_cnt (pulse_cnt),
    .pulse_out (pulse_out),
    .busy      (busy),
    .done      (done)
`ifdef PULSE_TRAIN_GEN_IDX_OUT_EN
    ,
    .pulse_idx (pulse_idx)
`endif
  );

`ifndef PULSE_TRAIN_GEN_IDX_OUT_EN
  assign pulse_idx = '0;
`endif

  always #5 clk = ~clk;

  typedef struct {
    bit     p;
    bit     b;
    bit     d;
    longint idx;
  } exp_t;

  exp_t sbq[$];
  int checks = 0;
  int errors = 0;

  bit     act = 0;
  longint t0, md, mw, mp, mc;
  longint idx_hold = 0;
  longint cyc = 0;
  bit     rst_nxt = 1'b1;

  task automatic chk(input string nm, input longint a, input longint e);
    checks++;
    if (a != e) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d", nm, cyc, a, e);
    end
  endtask

  // Outputs for cycle n, from the train's start time and plain arithmetic.
  function automatic exp_t exp_at(input longint n);
    exp_t   e;
    longint j, k, r, tend;
    e.p = 0;
    e.b = 0;
    e.d = 0;
    e.idx = idx_hold;
    if (act) begin
      j = n - t0;
      tend = md + (mc - 1) * mp + mw;
      if (j >= 1) begin
        e.b = (mc == 0) || (j <= tend);
        e.d = (mc != 0) && (j == tend + 1);
        e.idx = 0;
        if (j >= 1 + md) begin
          k = (j - 1 - md) / mp;
          r = (j - 1 - md) % mp;
          if (mc == 0 || k < mc) e.p = (r < mw);
          e.idx = (mc != 0 && k >= mc) ? mc - 1 : k;
        end
      end
    end
    return e;
  endfunction

  task automatic step(input bit s, input bit sp, input longint d,
                      input longint w, input longint p, input longint c);
    exp_t cur;
    @(negedge clk);
    rst = rst_nxt;
    start = s;
    stop = sp;
    delay_num = W'(d);
    width_num = W'(w);
    period_num = W'(p);
    pulse_cnt = W'(c);
    if (!rst) begin
      cur = exp_at(cyc);
      if (sp && cur.b) begin
        idx_hold = cur.idx;
        act = 0;
      end else if (s && !cur.b) begin
        act = 1;
        t0 = cyc;
        md = d;
        mw = (w == 0) ? 1 : ((w > MAXW) ? MAXW : w);
        mp = (p > mw) ? p : mw + 1;
        mc = c;
      end
    end
    sbq.push_back(exp_at(cyc + 1));
    cyc++;
  endtask

  task automatic idle();
    step(0, 0, $urandom_range(0, 9), $urandom_range(0, 9),
         $urandom_range(0, 9), $urandom_range(0, 5));
  endtask

  task automatic run(input longint d, input longint w, input longint p,
                     input longint c, input int n);
    step(1, 0, d, w, p, c);
    repeat (n) idle();
  endtask

  task automatic async_reset();
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_pulse", pulse_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    sbq.delete();
    act = 0;
    idx_hold = 0;
    rst_nxt = 1'b1;
    repeat (2) idle();
    rst_nxt = 1'b0;
  endtask

  // Monitor: compare each registered output cycle against the queue head.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("pulse_out", pulse_out, e.p);
        chk("busy", busy, e.b);
        chk("done", done, e.d);
`ifdef PULSE_TRAIN_GEN_IDX_OUT_EN
        chk("pulse_idx", pulse_idx, e.idx);
`endif
      end
    end
  end

  initial begin
    repeat (3) idle();
    rst_nxt = 1'b0;
    repeat (2) idle();
    run(2, 3, 5, 2, 14);
    run(0, 0, 0, 3, 8);
    run(1, 2, 4, 0, 5);
    step(1, 1, 0, 1, 1, 1);
    repeat (3) idle();
    run(0, 1, 1, 1, 4);
    run(0, 4, 8, 3, 5);
    step(1, 0, 0, 1, 1, 1);
    repeat (20) idle();
    run(3, 2, 6, 3, 20);
    run(0, 4, 8, 0, 2);
    async_reset();
    run(1, 2, 3, 2, 10);
    run(0, 5, 2, 2, 14);
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 7) == 0)
        step(1, $urandom_range(0, 15) == 0, $urandom_range(0, 5),
             $urandom_range(0, 6), $urandom_range(0, 12),
             $urandom_range(0, 4));
      else if ($urandom_range(0, 39) == 0)
        step(0, 1, 0, 0, 0, 0);
      else
        idle();
    end
    repeat (3) begin
      @(negedge clk);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pulse_train_gen.md
# pulse_train_gen

Programmable pulse-train generator that produces a delayed, bounded or free-running sequence of fixed-width pulses on request. It sits directly upstream of the pulse stretcher stage (pulse_hold), feeding it clean, edge-separated pulses. It also drives any other consumer that needs software-timed strobes.

## Interface
- CNT_W, default 32: width of all timing/count fields and internal counters.
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  request a train; sampled only in IDLE.
- stop  in  1  abort the running train; ignored in IDLE.
- delay_num  in  CNT_W  cycles from start acceptance to first rising edge (0 allowed).
- width_num  in  CNT_W  high cycles per pulse.
- period_num  in  CNT_W  cycles from one rising edge to the next.
- pulse_cnt  in  CNT_W  pulses to emit; 0 = infinite until stop.
- pulse_out  out  1  registered pulse train.
- busy  out  1  high while a train is in progress.
- done  out  1  one-cycle strobe on natural completion.
- pulse_idx  out  CNT_W  index of current/last pulse, 0-based; present only with PULSE_TRAIN_GEN_IDX_OUT_EN.

## Operation
- States: IDLE, DELAY, HIGH, LOW.
- IDLE + start: latch all config and go to DELAY, or to HIGH if delay_num==0.
- Config sanitisation at latch:
  - width = clamp(width_num, 1, 2^CNT_W-2).
  - period = max(period_num, width+1), so every pulse has at least 1 low cycle before the next. The downstream edge detector needs this gap.
- DELAY: count delay cycles, then go to HIGH.
- HIGH: pulse_out=1 for width cycles. At the end:
  - if this was the last pulse (pulse_cnt≠0 and emitted==pulse_cnt), go to IDLE and pulse done;
  - otherwise go to LOW.
- LOW: pulse_out=0 for period-width cycles, then go to HIGH.
- The emitted counter increments on entry to HIGH. In infinite mode it wraps silently and never terminates.
- stop in any non-IDLE state: go to IDLE next cycle, pulse_out=0, busy=0, no done.
- start while busy: ignored, whatever the config. start and stop in the same cycle: when busy, stop wins; in IDLE, start is accepted.
- Config inputs may change freely after acceptance without affecting the running train.

## Timing
- Reset values: pulse_out=0, busy=0, done=0, pulse_idx=0, state IDLE. Reset asserted mid-train clears the outputs immediately (async), with no done.
- Start accepted at edge T: busy=1 from T+1.
- First rising edge of pulse_out at T+1+delay_num.
- Pulse k (0-based) is high over cycles [T+1+delay_num+k·period, +width-1].
- Last pulse falls at cycle F. At F: done=1 for exactly one cycle, busy=0, and start is accepted again at F.
- No trailing low phase after the last pulse.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- PULSE_TRAIN_GEN_IDX_OUT_EN defined: the pulse_idx port exists.
  - It is set to 0 on start acceptance and increments on each subsequent HIGH entry.
  - It holds its value after done or stop.
- Macro undefined: the port and its register are absent; all other behaviour is identical.

## Structure
- Shared package pulse_pkg holds:
  - the state enum typedef pulse_gen_state_t (IDLE, DELAY, HIGH, LOW);
  - the default CNT_W constant;
  - the sanitisation helper function, which is shared with future pulse-family blocks.
- Single flat module with one phase counter, reused across DELAY, HIGH and LOW, plus one emitted-pulse counter. No sub-module is needed.

## Test plan
- delay=2, width=3, period=5, cnt=2, start at T -> busy T+1..T+10; pulse_out high T+3..T+5 and T+8..T+10; done at T+11 only.
- delay=0, width=0, period=0, cnt=3 -> sanitised to width 1, period 2; pulse_out high at T+1, T+3, T+5; done at T+6.
- cnt=0, width=2, period=4, stop asserted at cycle S during HIGH -> pulse_out=0 and busy=0 at S+1; done never asserted; next start accepted.
- Running train (width=4, period=8); start pulsed with width=1 mid-train -> ignored, all pulses remain 4 high.
- rst asserted asynchronously mid-HIGH -> pulse_out and busy drop before the next edge; after release, start produces a normal train.
- With PULSE_TRAIN_GEN_IDX_OUT_EN, cnt=3 -> pulse_idx reads 0, 1, 2 during the respective pulses and holds 2 after done.
